multicycle_processor: RTL and testbench

- Next-generation MIPS-subset core: a multi-cycle FSM that replaces the single-cycle datapath.
- Uses one shared instruction/data memory bus with a request/ready handshake, so it tolerates variable-latency memory.
- Contains the PC, IR, a 32x32 register file, the ALU and all control.
- Reports halt status, halt cause and retired-instruction count to the testbench/top.

---
 rtl/multicycle_processor.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_processor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_processor.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT over one shared
// req/ready memory bus, with register file, ALU, halt reporting and retire count.
module multicycle_processor #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              start_up,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic [2:0]        state;
  logic [31:0]       ir, a, b, alu_out, mdr;
  logic [ADDR_W-1:0] npc;
  logic [31:0]       regs [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] imm_s, imm_z, ea, r_result, wb_data, npc32, j_target;
  logic        legal, taken;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_s    = {{16{ir[15]}}, ir[15:0]};
  assign imm_z    = {16'h0000, ir[15:0]};
  assign ea       = a + imm_s;
  assign taken    = (op == OP_BEQ) ? (a == b) : (a != b);
  assign dest     = (op == OP_RTYPE) ? rd : rt;
  assign wb_data  = (op == OP_LW) ? mdr : alu_out;
  assign npc32    = 32'(npc);
  assign j_target = {npc32[31:28], ir[25:0], 2'b00};

  // Reset gates the bus strobes directly so an in-flight request drops without a clock edge.
  assign mem_req   = start_up && (state == S_FETCH || state == S_MEM);
  assign mem_we    = start_up && (state == S_MEM) && (op == OP_SW);
  assign mem_addr  = (state == S_MEM) ? ADDR_W'(alu_out) : pc;
  assign mem_wdata = b;
  assign halted    = (state == S_HALT);

  always_comb begin
    r_result = 32'h0;
    case (funct)
      F_ADD:   r_result = a + b;
      F_SUB:   r_result = a - b;
      F_AND:   r_result = a & b;
      F_OR:    r_result = a | b;
      F_SLT:   r_result = {31'h0, $signed(a) < $signed(b)};
      default: r_result = 32'h0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                        (funct == F_OR)  || (funct == F_SLT);
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge start_up) begin
    if (!start_up) begin
      state      <= S_FETCH;
      pc         <= ADDR_W'(RESET_PC);
      npc        <= '0;
      ir         <= 32'h0;
      a          <= 32'h0;
      b          <= 32'h0;
      alu_out    <= 32'h0;
      mdr        <= 32'h0;
      halt_cause <= 2'b00;
      retired    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            npc   <= pc + ADDR_W'(4);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
          if (ir == 32'hFFFF_FFFF) begin
            halt_cause <= 2'b01;
            state      <= S_HALT;
          end else if (!legal) begin
            halt_cause <= 2'b10;
            state      <= S_HALT;
          end else if (op == OP_J) begin
            pc      <= ADDR_W'(j_target);
            retired <= retired + CNT_W'(1);
            state   <= S_FETCH;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op == OP_RTYPE) begin
            alu_out <= r_result;
            state   <= S_WB;
          end else if (op == OP_ADDI) begin
            alu_out <= a + imm_s;
            state   <= S_WB;
          end else if (op == OP_ANDI) begin
            alu_out <= a & imm_z;
            state   <= S_WB;
          end else if (op == OP_ORI) begin
            alu_out <= a | imm_z;
            state   <= S_WB;
          end else if (op == OP_LW || op == OP_SW) begin
            // A misaligned address never reaches the bus.
            if (ea[1:0] != 2'b00) begin
              halt_cause <= 2'b11;
              state      <= S_HALT;
            end else begin
              alu_out <= ea;
              state   <= S_MEM;
            end
          end else begin
            pc      <= taken ? npc + ADDR_W'(imm_s << 2) : npc;
            retired <= retired + CNT_W'(1);
            state   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_SW) begin
              pc      <= npc;
              retired <= retired + CNT_W'(1);
              state   <= S_FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          pc      <= npc;
          retired <= retired + CNT_W'(1);
          state   <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Register $0 is never written, so it always reads as zero.
  always_ff @(posedge clk or negedge start_up) begin
    if (!start_up) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (state == S_WB && dest != 5'd0) begin
      regs[dest] <= wb_data;
    end
  end

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor: an instruction-level model builds the
// expected per-cycle bus/status trace, which is compared every cycle, plus literal pins.
module tb_multicycle_processor;

  logic        clk;
  logic        start_up;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] retired;

  multicycle_processor dut (
    .clk(clk), .start_up(start_up),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .halted(halted), .halt_cause(halt_cause), .retired(retired)
  );

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] ret;
    bit          hal;
    logic [1:0]  cause;
  } cyc_t;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  int          tests, failures;
  int          wait_cycles, wcnt;
  logic        load_now;
  logic [31:0] img [256];
  logic [31:0] mem [256];
  logic [31:0] mm [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_ret;
  cyc_t        tl [$];
  int          first_halt, req_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory answers after wait_cycles stalled cycles of each request.
  assign mem_ready = mem_req && (wcnt == wait_cycles);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_now) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  function automatic logic [31:0] encR(int rs, int rt, int rd, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] encI(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] encJ(int target);
    return {6'd2, 26'(target >> 2)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearImg();
    for (int i = 0; i < 256; i++) img[i] = 32'h0;
  endtask

  task automatic pushCyc(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] p,
                         input logic [31:0] r, input bit hal, input logic [1:0] cause);
    cyc_t e;
    e.req = req; e.we = we; e.addr = addr; e.wdata = wdata;
    e.pc = p; e.ret = r; e.hal = hal; e.cause = cause;
    tl.push_back(e);
  endtask

  // Instruction-level execution of img; each instruction contributes its phase cycles.
  task automatic buildTimeline(input int w);
    logic [31:0] p, ir, a, b, sx, zx, ea, res, np;
    int          op, rs, rt, rd, fn, dest, cause;
    bit          wr, redirect;
    tl.delete();
    for (int i = 0; i < 256; i++) mm[i] = img[i];
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    p = 32'h0; m_ret = 32'h0; cause = 0;
    for (int n = 0; n < 200 && cause == 0; n++) begin
      ir = mm[p[9:2]];
      repeat (w + 1) pushCyc(1, 0, p, 0, p, m_ret, 0, 0);
      pushCyc(0, 0, 0, 0, p, m_ret, 0, 0);
      op = int'(ir[31:26]); rs = int'(ir[25:21]); rt = int'(ir[20:16]);
      rd = int'(ir[15:11]); fn = int'(ir[5:0]);
      a = m_regs[rs]; b = m_regs[rt];
      sx = {{16{ir[15]}}, ir[15:0]}; zx = {16'h0, ir[15:0]};
      np = p + 32'd4;
      wr = 0; redirect = 0; dest = 0; res = 0;
      if (ir == HALT_W) cause = 1;
      else if (op == 2) begin
        p = {np[31:28], ir[25:0], 2'b00};
        redirect = 1;
      end else if (op == 4 || op == 5) begin
        pushCyc(0, 0, 0, 0, p, m_ret, 0, 0);
        p = (((a == b) ? 1 : 0) == ((op == 4) ? 1 : 0)) ? np + (sx << 2) : np;
        redirect = 1;
      end else if (op == 0) begin
        case (fn)
          'h20: res = a + b;
          'h22: res = a - b;
          'h24: res = a & b;
          'h25: res = a | b;
          'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: cause = 2;
        endcase
        if (cause == 0) begin
          wr = 1; dest = rd;
          pushCyc(0, 0, 0, 0, p, m_ret, 0, 0);
          pushCyc(0, 0, 0, 0, p, m_ret, 0, 0);
        end
      end else if (op == 'h08 || op == 'h0C || op == 'h0D) begin
        res = (op == 'h08) ? a + sx : (op == 'h0C) ? (a & zx) : (a | zx);
        wr = 1; dest = rt;
        pushCyc(0, 0, 0, 0, p, m_ret, 0, 0);
        pushCyc(0, 0, 0, 0, p, m_ret, 0, 0);
      end else if (op == 'h23 || op == 'h2B) begin
        pushCyc(0, 0, 0, 0, p, m_ret, 0, 0);
        ea = a + sx;
        if (ea[1:0] != 2'b00) cause = 3;
        else begin
          repeat (w + 1) pushCyc(1, op == 'h2B, ea, b, p, m_ret, 0, 0);
          if (op == 'h2B) mm[ea[9:2]] = b;
          else begin
            res = mm[ea[9:2]]; wr = 1; dest = rt;
            pushCyc(0, 0, 0, 0, p, m_ret, 0, 0);
          end
        end
      end else cause = 2;
      if (cause == 0) begin
        if (wr && dest != 0) m_regs[dest] = res;
        if (!redirect) p = np;
        m_ret = m_ret + 32'd1;
      end
    end
    repeat (4) pushCyc(0, 0, 0, 0, p, m_ret, 1, 2'(cause));
  endtask

  task automatic applyStimulus(input int w);
    start_up = 1'b0;
    wait_cycles = w;
    load_now = 1'b1;
    @(posedge clk);
    #1 load_now = 1'b0;
    checkOutput("reset mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset retired", retired, 32'h0);
    checkOutput("reset halted", {31'h0, halted}, 32'h0);
    @(posedge clk);
    #1 start_up = 1'b1;
  endtask

  task automatic checkCycles(input string tag);
    cyc_t e;
    first_halt = -1;
    req_count = 0;
    for (int k = 0; k < tl.size(); k++) begin
      @(negedge clk);
      e = tl[k];
      checkOutput($sformatf("%s c%0d mem_req", tag, k), {31'h0, mem_req}, {31'h0, e.req});
      if (e.req) begin
        checkOutput($sformatf("%s c%0d mem_we", tag, k), {31'h0, mem_we}, {31'h0, e.we});
        checkOutput($sformatf("%s c%0d mem_addr", tag, k), mem_addr, e.addr);
        if (e.we) checkOutput($sformatf("%s c%0d mem_wdata", tag, k), mem_wdata, e.wdata);
      end
      checkOutput($sformatf("%s c%0d pc", tag, k), pc, e.pc);
      checkOutput($sformatf("%s c%0d retired", tag, k), retired, e.ret);
      checkOutput($sformatf("%s c%0d halted", tag, k), {31'h0, halted}, {31'h0, e.hal});
      checkOutput($sformatf("%s c%0d cause", tag, k), {30'h0, halt_cause}, {30'h0, e.cause});
      if (mem_req) req_count++;
      if (halted && first_halt < 0) first_halt = k;
    end
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("%s reg%0d", tag, i), dut.regs[i], m_regs[i]);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    tests = 0; failures = 0;
    start_up = 1'b0; load_now = 1'b0; wait_cycles = 0;

    // Arithmetic with zero-wait memory.
    clearImg();
    img[0] = encI(8, 0, 1, 5);
    img[1] = encI(8, 0, 2, -3);
    img[2] = encR(1, 2, 3, 'h20);
    img[3] = encR(2, 1, 4, 'h2A);
    img[4] = HALT_W;
    buildTimeline(0); applyStimulus(0); checkCycles("t1"); checkRegs("t1");
    checkOutput("t1 r3", dut.regs[3], 32'd2);
    checkOutput("t1 r4", dut.regs[4], 32'd1);
    checkOutput("t1 retired", retired, 32'd4);
    checkOutput("t1 cause", {30'h0, halt_cause}, 32'd1);
    checkOutput("t1 halt cycle", first_halt, 32'd18);

    // Store/load with two wait cycles on every access.
    clearImg();
    img[0] = encJ('h10);
    img[4] = encI('h23, 0, 1, 'h80);
    img[5] = encI('h2B, 0, 1, 8);
    img[6] = encI('h23, 0, 5, 8);
    img[7] = HALT_W;
    img[32] = 32'hDEAD_BEEF;
    buildTimeline(2); applyStimulus(2); checkCycles("t2"); checkRegs("t2");
    checkOutput("t2 r5", dut.regs[5], 32'hDEAD_BEEF);
    checkOutput("t2 mem8", mem[2], 32'hDEAD_BEEF);
    checkOutput("t2 retired", retired, 32'd4);
    checkOutput("t2 halt cycle", first_halt, 32'd34);

    // Counting loop with bne back-edge, then jump to HALT at 0x40.
    clearImg();
    img[0]  = encI(8, 0, 2, 3);
    img[1]  = encI(8, 1, 1, 1);
    img[2]  = encI(5, 1, 2, -2);
    img[3]  = encJ('h40);
    img[16] = HALT_W;
    buildTimeline(0); applyStimulus(0); checkCycles("t3"); checkRegs("t3");
    checkOutput("t3 r1", dut.regs[1], 32'd3);
    checkOutput("t3 pc", pc, 32'h40);
    checkOutput("t3 retired", retired, 32'd8);
    checkOutput("t3 halt cycle", first_halt, 32'd29);

    // Misaligned load halts before any data access.
    clearImg();
    img[0] = encI('h23, 0, 1, 2);
    buildTimeline(0); applyStimulus(0); checkCycles("t4a");
    checkOutput("t4a cause", {30'h0, halt_cause}, 32'd3);
    checkOutput("t4a retired", retired, 32'd0);
    checkOutput("t4a req cycles", req_count, 32'd1);
    checkOutput("t4a halt cycle", first_halt, 32'd3);

    // Writes to $0 are discarded; illegal opcode halts.
    clearImg();
    img[0] = encI(8, 0, 2, 9);
    img[1] = encI(8, 0, 0, 7);
    img[2] = encR(0, 0, 2, 'h20);
    img[3] = 32'hFC00_0000;
    buildTimeline(0); applyStimulus(0); checkCycles("t4b"); checkRegs("t4b");
    checkOutput("t4b r0", dut.regs[0], 32'd0);
    checkOutput("t4b r2", dut.regs[2], 32'd0);
    checkOutput("t4b cause", {30'h0, halt_cause}, 32'd2);
    checkOutput("t4b retired", retired, 32'd3);
    checkOutput("t4b halt cycle", first_halt, 32'd14);

    // Logic ops, sub, taken beq skipping an instruction, illegal funct, one wait cycle.
    clearImg();
    img[0] = encI('h0D, 0, 1, 'hF0F0);
    img[1] = encI('h0C, 1, 2, 'h00FF);
    img[2] = encI(8, 0, 3, -1);
    img[3] = encR(2, 3, 4, 'h22);
    img[4] = encR(3, 1, 5, 'h24);
    img[5] = encR(2, 4, 6, 'h25);
    img[6] = encI(4, 5, 1, 1);
    img[7] = encI(8, 0, 7, 1);
    img[8] = encR(0, 0, 8, 'h21);
    buildTimeline(1); applyStimulus(1); checkCycles("t4c"); checkRegs("t4c");
    checkOutput("t4c r4", dut.regs[4], 32'h0000_00F1);
    checkOutput("t4c r6", dut.regs[6], 32'h0000_00F1);
    checkOutput("t4c r7", dut.regs[7], 32'd0);
    checkOutput("t4c cause", {30'h0, halt_cause}, 32'd2);
    checkOutput("t4c retired", retired, 32'd7);

    // Asynchronous reset while a load is stalled in MEM.
    clearImg();
    img[0] = encI(8, 0, 2, 1);
    img[1] = encI('h23, 0, 1, 'h80);
    img[2] = HALT_W;
    img[32] = 32'h1234_5678;
    applyStimulus(3);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 32'h80) found = 1;
    end
    checkOutput("t5 reached MEM", {31'h0, found}, 32'd1);
    checkOutput("t5 retired before", retired, 32'd1);
    #2 start_up = 1'b0;
    #1;
    checkOutput("t5 async mem_req", {31'h0, mem_req}, 32'd0);
    checkOutput("t5 async mem_we", {31'h0, mem_we}, 32'd0);
    checkOutput("t5 async pc", pc, 32'h0);
    checkOutput("t5 async retired", retired, 32'd0);
    checkOutput("t5 async halted", {31'h0, halted}, 32'd0);
    buildTimeline(0); applyStimulus(0); checkCycles("t5"); checkRegs("t5");
    checkOutput("t5 r1", dut.regs[1], 32'h1234_5678);
    checkOutput("t5 halt cycle", first_halt, 32'd11);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
